// File: rtl/uart_pkg.sv
// Shared state encoding and oversampling constants for the UART receiver.
package uart_pkg;

  localparam int OVERSAMPLE        = 16;
  localparam int MID_TICK          = 7;
  localparam int DATA_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for one asynchronous input with a selectable reset value.
// Output lags the input by 2 clk cycles; there is no backpressure.
module rx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver; rx_done_tick fires one clk after the tick ending the stop bit, no backpressure.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEFAULT,
  parameter int SB_TICK   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done_tick,
  output logic                 frame_err,
  output logic                 parity_err
);

  localparam logic [4:0] MID_S  = 5'(MID_TICK);
  localparam logic [4:0] LAST_S = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_S = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_N = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam uart_rx_state_t AFTER_DATA = PARITY;
`else
  localparam uart_rx_state_t AFTER_DATA = STOP;
`endif

  uart_rx_state_t state_q, state_d;
  logic [4:0]           s_q, s_d;
  logic [2:0]           n_q, n_d;
  logic [DATA_BITS-1:0] b_q, b_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;
  logic                 rx_prev_q;
  logic                 fall;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  rx_sync #(.RST_VAL(1'b1)) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rx_s)
  );

  // Start needs a true high-to-low transition, so a line left low after a bad stop bit cannot retrigger.
  assign fall = rx_prev_q & ~rx_s;

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == MID_S) begin
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == LAST_S) begin
            s_d = '0;
            b_d = {rx_s, b_q[DATA_BITS-1:1]};
            if (n_q == LAST_N) state_d = AFTER_DATA;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (s_q == LAST_S) begin
            s_d     = '0;
            par_d   = rx_s;
            state_d = STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (s_q == STOP_S) begin
            dout_d  = b_q;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            perr_d  = ^{b_q, par_q};
`endif
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      n_q       <= '0;
      b_q       <= '0;
      dout_q    <= '0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      b_q       <= b_d;
      dout_q    <= dout_d;
      done_q    <= done_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_s;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err   = perr_q;
`else
  assign parity_err   = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART serial receiver with 16x oversampling. Sits directly downstream of the baud-rate generator and consumes its single-cycle `tick` strobe, which fires 16 times per bit period. It detects start bits, samples each bit at its centre, and presents one assembled byte per frame, qualified by a one-cycle done strobe. It also reports frame and parity errors.

## Interface
Parameters:
- `DATA_BITS`, 8: payload bits per frame, LSB first; legal range 5–8.
- `SB_TICK`, 16: ticks spent in the stop state (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: reset, asynchronous and active-low.
- `tick` input 1: oversampling strobe from the baud generator; high for exactly one `clk` cycle.
- `rx` input 1: serial line, asynchronous to `clk`; idles high.
- `dout` output DATA_BITS: last received payload.
- `rx_done_tick` output 1: one-cycle strobe marking a valid new `dout`.
- `frame_err` output 1: valid only while `rx_done_tick` is high; stop bit was sampled low.
- `parity_err` output 1: valid only while `rx_done_tick` is high; see Configuration.

## Operation
- `rx` passes through a two-flop synchronizer before use. Both flops reset to 1.
- Only the synchronized `rx` (`rx_s`) is used past this point.
- Tick counter `s` is 5 bits. Bit counter `n` is 3 bits. Shift register `b` is DATA_BITS wide.
- The FSM has states IDLE, START, DATA, PARITY, STOP. PARITY exists only with the macro.
- `s` and `n` advance only on cycles where `tick` = 1. FSM decisions are made only on tick cycles, except IDLE exit.
- IDLE:
  - On a falling `rx_s` (level 0), go to START and set `s`=0. This happens on any cycle, with no tick required.
- START:
  - When `s`=7 on a tick (the middle of the start bit), check `rx_s`.
  - If `rx_s`=0: go to DATA with `s`=0 and `n`=0.
  - If `rx_s`=1: treat it as a glitch and return to IDLE. No strobe is produced.
- DATA:
  - When `s`=15 on a tick, shift right and load `rx_s` into `b[DATA_BITS-1]`. Then set `s`=0.
  - When `n`=DATA_BITS-1, go to PARITY if it exists, otherwise to STOP. Otherwise `n`++.
- PARITY:
  - When `s`=15 on a tick, latch `rx_s` as the parity bit. Set `s`=0 and go to STOP.
- STOP:
  - When `s`=SB_TICK-1 on a tick, sample `rx_s`.
  - Register `dout`←`b`, `frame_err`←~`rx_s`, and `parity_err`. Pulse `rx_done_tick` and go to IDLE.
- A frame with a bad stop bit still delivers `dout`, with `frame_err`=1. The receiver then waits in IDLE for the next falling edge, so a held-low line does not retrigger until it has returned high.
- `dout` holds its value until the next `rx_done_tick`.

## Timing
- Reset values:
  - `dout`=0, `rx_done_tick`=0, `frame_err`=0, `parity_err`=0.
  - FSM in IDLE, `s`=0, `n`=0, `b`=0, synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame immediately. No strobe is produced. Reception resumes with the next falling edge after release.
- Latency from the `rx` edge to IDLE exit is 2 `clk` cycles (synchronizer) plus 1 cycle.
- `rx_done_tick` goes high on the `clk` cycle after the tick that ends STOP, for exactly 1 cycle. `dout`, `frame_err` and `parity_err` update on that same edge.
- A start edge arriving on the cycle immediately after STOP exit is accepted. Back-to-back frames need no gap beyond the stop bit.
- `tick` high for more than one cycle is out of contract. Each high cycle counts as a tick.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state is compiled in and one parity bit follows the data bits.
  - `parity_err` = 1 when the XOR of the data bits and the parity bit is 1 (even parity expected).
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; the frame goes straight from DATA to STOP.
  - The `parity_err` port still exists and is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP);
  - the constant `OVERSAMPLE`=16 and the mid-bit constant `MID_TICK`=7;
  - the default `DATA_BITS`.
- Sub-module `rx_sync` is the two-flop synchronizer, parameterized by reset value (1 here). It is reusable for other asynchronous inputs.
- The FSM, counters and output registers stay in `uart_rx`.

## Test plan
Bench setup: 100 MHz `clk`, `tick` every 325 cycles (19200 baud), so 1 bit = 16 ticks = 5200 cycles.
- Send 0x55 with a good stop bit -> exactly one `rx_done_tick`, `dout`=0x55, `frame_err`=0, `parity_err`=0.
- Send 0xA3 then 0x0F back-to-back with no idle gap -> two strobes, `dout`=0xA3 then 0x0F.
- Drive `rx` low for 3 ticks, then back high -> no strobe, FSM back in IDLE, next frame 0x3C received correctly.
- Send 0x81 with the stop bit driven low -> strobe with `dout`=0x81 and `frame_err`=1. No new frame starts until `rx` has gone high and then fallen again.
- Assert `rst_n`=0 during data bit 4 of a frame -> all outputs 0 and no strobe. After release, frame 0xC6 is received correctly.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 1 -> `parity_err`=0. Send 0x07 with parity bit 0 -> `parity_err`=1.
